// File: rtl/pipe_pkg.sv
// Shared types for the ready/valid pipeline stage registers.
// Stage occupancy states and the default bubble encoding.
package pipe_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  localparam logic [15:0] DEFAULT_NOP = 16'h0000;

endpackage

// File: rtl/pipe_entry_reg.sv
// Payload register with load and clear; used for the main and skid entries.
// Clear wins over load so a flush always leaves a bubble.
module pipe_entry_reg #(
  parameter int           W       = 32,
  parameter logic [W-1:0] CLR_VAL = '0
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clear,
  input  logic         load,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  always_ff @(posedge clk) begin
    if (!reset || clear) q <= CLR_VAL;
    else if (load)       q <= d;
  end

endmodule

// File: rtl/pipe_skid_reg.sv
// Ready/valid pipeline stage with a two-entry skid buffer, flush-to-bubble
// and a saturating stall counter. in_ready is decoded from the state register only.
module pipe_skid_reg
  import pipe_pkg::*;
#(
  parameter int                   INSTR_W   = 16,
  parameter int                   PC_W      = 16,
  parameter logic [INSTR_W-1:0]   NOP_INSTR = INSTR_W'(DEFAULT_NOP),
  parameter int                   CNT_W     = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [INSTR_W-1:0] in_instr,
  input  logic [PC_W-1:0]    in_pc,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [INSTR_W-1:0] out_instr,
  output logic [PC_W-1:0]    out_pc,
  output logic [CNT_W-1:0]   stall_cnt
);

  localparam int               ENT_W   = INSTR_W + PC_W;
  localparam logic [ENT_W-1:0] CLR_ENT = {NOP_INSTR, {PC_W{1'b0}}};

  state_t           state, state_nxt;
  logic             in_fire, out_fire;
  logic             main_load, main_clear, main_sel_skid, skid_load;
  logic [ENT_W-1:0] in_ent, main_d, main_q, skid_q;

  assign in_ready  = (state != TWO);
  assign out_valid = (state != EMPTY);
  assign in_fire   = in_valid & in_ready;
  assign out_fire  = out_valid & out_ready;
  assign in_ent    = {in_instr, in_pc};
  assign main_d    = main_sel_skid ? skid_q : in_ent;

  always_ff @(posedge clk) begin
    if (!reset) state <= EMPTY;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt     = state;
    main_load     = 1'b0;
    main_clear    = 1'b0;
    main_sel_skid = 1'b0;
    skid_load     = 1'b0;
    if (flush) begin
      state_nxt  = EMPTY;
      main_clear = 1'b1;
    end else begin
      case (state)
        EMPTY: begin
          if (in_fire) begin
            main_load = 1'b1;
            state_nxt = ONE;
          end
        end
        ONE: begin
          if (in_fire && out_fire) begin
            main_load = 1'b1;
          end else if (in_fire) begin
            skid_load = 1'b1;
            state_nxt = TWO;
          end else if (out_fire) begin
            // Draining to empty also restores the bubble on the outputs.
            main_clear = 1'b1;
            state_nxt  = EMPTY;
          end
        end
        TWO: begin
          if (out_fire) begin
            main_load     = 1'b1;
            main_sel_skid = 1'b1;
            state_nxt     = ONE;
          end
        end
        default: state_nxt = EMPTY;
      endcase
    end
  end

  pipe_entry_reg #(.W(ENT_W), .CLR_VAL(CLR_ENT)) u_main (
    .clk   (clk),
    .reset (reset),
    .clear (main_clear),
    .load  (main_load),
    .d     (main_d),
    .q     (main_q)
  );

  pipe_entry_reg #(.W(ENT_W), .CLR_VAL(CLR_ENT)) u_skid (
    .clk   (clk),
    .reset (reset),
    .clear (flush),
    .load  (skid_load),
    .d     (in_ent),
    .q     (skid_q)
  );

  assign {out_instr, out_pc} = main_q;

  always_ff @(posedge clk) begin
    if (!reset)
      stall_cnt <= '0;
    else if (out_valid && !out_ready && !flush && (stall_cnt != {CNT_W{1'b1}}))
      stall_cnt <= stall_cnt + CNT_W'(1);
  end

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Bench for pipe_skid_reg: directed vector table, hand sequences and a
// randomized run against a queue-based reference model.
module tb_pipe_skid_reg;

  logic        clk = 1'b0;
  logic        reset, flush, in_valid, out_ready;
  logic [15:0] in_instr, in_pc;
  logic        in_ready, out_valid;
  logic [15:0] out_instr, out_pc, stall_cnt;

  logic        in_valid2, in_ready2, out_valid2;
  logic [15:0] out_instr2, out_pc2;
  logic [3:0]  stall_cnt2;
  logic        flush2    = 1'b0;
  logic        out_ready2 = 1'b0;
  logic [15:0] in_instr2 = 16'h5555;
  logic [15:0] in_pc2    = 16'h0042;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  pipe_skid_reg dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr), .out_pc(out_pc),
    .stall_cnt(stall_cnt)
  );

  pipe_skid_reg #(.CNT_W(4)) dut4 (
    .clk(clk), .reset(reset), .flush(flush2),
    .in_valid(in_valid2), .in_ready(in_ready2), .in_instr(in_instr2), .in_pc(in_pc2),
    .out_valid(out_valid2), .out_ready(out_ready2), .out_instr(out_instr2), .out_pc(out_pc2),
    .stall_cnt(stall_cnt2)
  );

  // Reference model: a FIFO of at most two entries plus a saturating counter.
  typedef struct packed { logic [15:0] instr; logic [15:0] pc; } ent_t;
  ent_t        mq[$];
  int unsigned m_cnt;

  typedef struct {
    logic iv; logic [15:0] instr; logic [15:0] pc; logic ordy; logic fl;
    logic eov; logic eir; logic [15:0] einstr; logic [15:0] epc; int estall;
  } vec_t;
  vec_t tbl[11];

  task automatic step();
    bit ir, ov, inf, outf;
    ir   = (mq.size() < 2);
    ov   = (mq.size() > 0);
    inf  = in_valid && ir;
    outf = ov && out_ready;
    @(posedge clk); #1;
    if (!reset) begin
      mq.delete();
      m_cnt = 0;
    end else if (flush) begin
      mq.delete();
    end else begin
      if (ov && !out_ready && m_cnt < 65535) m_cnt++;
      if (outf) void'(mq.pop_front());
      if (inf)  mq.push_back('{in_instr, in_pc});
    end
  endtask

  task automatic check(string tag, logic eov, logic eir, logic [15:0] ei, logic [15:0] ep, int es);
    checks++;
    if (out_valid !== eov || in_ready !== eir || out_instr !== ei || out_pc !== ep || stall_cnt !== 16'(es)) begin
      errors++;
      $display("FAIL %s: got ov=%0b ir=%0b instr=%h pc=%h stall=%0d, want ov=%0b ir=%0b instr=%h pc=%h stall=%0d",
               tag, out_valid, in_ready, out_instr, out_pc, stall_cnt, eov, eir, ei, ep, es);
    end
  endtask

  task automatic check_model(string tag);
    ent_t e;
    e = (mq.size() > 0) ? mq[0] : '{16'h0000, 16'h0000};
    check(tag, mq.size() > 0, mq.size() < 2, e.instr, e.pc, int'(m_cnt));
  endtask

  task automatic drive(logic iv, logic [15:0] ins, logic [15:0] pc, logic ordy, logic fl);
    in_valid = iv; in_instr = ins; in_pc = pc; out_ready = ordy; flush = fl;
  endtask

  initial begin
    tbl[0]  = '{1'b1, 16'h1234, 16'h0002, 1'b1, 1'b0, 1'b1, 1'b1, 16'h1234, 16'h0002, 0};
    tbl[1]  = '{1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b1, 16'h0000, 16'h0000, 0};
    tbl[2]  = '{1'b1, 16'hAAAA, 16'h0010, 1'b0, 1'b0, 1'b1, 1'b1, 16'hAAAA, 16'h0010, 0};
    tbl[3]  = '{1'b1, 16'hBBBB, 16'h0012, 1'b0, 1'b0, 1'b1, 1'b0, 16'hAAAA, 16'h0010, 1};
    tbl[4]  = '{1'b1, 16'hCCCC, 16'h0014, 1'b0, 1'b0, 1'b1, 1'b0, 16'hAAAA, 16'h0010, 2};
    tbl[5]  = '{1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b1, 16'hBBBB, 16'h0012, 2};
    tbl[6]  = '{1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b1, 16'h0000, 16'h0000, 2};
    tbl[7]  = '{1'b1, 16'hDDDD, 16'h0020, 1'b0, 1'b0, 1'b1, 1'b1, 16'hDDDD, 16'h0020, 2};
    tbl[8]  = '{1'b1, 16'hEEEE, 16'h0022, 1'b0, 1'b0, 1'b1, 1'b0, 16'hDDDD, 16'h0020, 3};
    tbl[9]  = '{1'b1, 16'hFFFF, 16'h0030, 1'b0, 1'b1, 1'b0, 1'b1, 16'h0000, 16'h0000, 3};
    tbl[10] = '{1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b1, 16'h0000, 16'h0000, 3};

    in_valid2 = 1'b0;
    reset = 1'b0;
    drive(1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
    step();
    check("reset_state", 1'b0, 1'b1, 16'h0000, 16'h0000, 0);
    reset = 1'b1;

    for (int i = 0; i < 11; i++) begin
      drive(tbl[i].iv, tbl[i].instr, tbl[i].pc, tbl[i].ordy, tbl[i].fl);
      step();
      check($sformatf("vec%0d", i), tbl[i].eov, tbl[i].eir, tbl[i].einstr, tbl[i].epc, tbl[i].estall);
    end

    // Full-rate stream: one output per cycle, in order, in_ready never drops.
    for (int i = 1; i <= 8; i++) begin
      drive(1'b1, 16'(i), 16'(2 * i), 1'b1, 1'b0);
      step();
      check($sformatf("stream%0d", i), 1'b1, 1'b1, 16'(i), 16'(2 * i), 3);
    end
    drive(1'b0, 16'h0, 16'h0, 1'b1, 1'b0);
    step();
    check("stream_drain", 1'b0, 1'b1, 16'h0000, 16'h0000, 3);

    // Reset mid-operation with stall_cnt at 5.
    reset = 1'b0; step(); reset = 1'b1;
    drive(1'b1, 16'h7777, 16'h0070, 1'b0, 1'b0);
    step();
    drive(1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) step();
    check("one_stall5", 1'b1, 1'b1, 16'h7777, 16'h0070, 5);
    reset = 1'b0;
    step();
    check("mid_reset", 1'b0, 1'b1, 16'h0000, 16'h0000, 0);
    reset = 1'b1;

    // Saturation on the 4-bit counter instance.
    in_valid2 = 1'b1;
    step();
    in_valid2 = 1'b0;
    for (int i = 0; i < 14; i++) step();
    checks++;
    if (stall_cnt2 !== 4'd14) begin
      errors++;
      $display("FAIL sat_pre: got stall=%0d, want 14", stall_cnt2);
    end
    for (int i = 0; i < 6; i++) step();
    checks++;
    if (stall_cnt2 !== 4'd15) begin
      errors++;
      $display("FAIL sat_hold: got stall=%0d, want 15", stall_cnt2);
    end

    // Randomized run against the reference model.
    for (int i = 0; i < 400; i++) begin
      reset = ($urandom_range(0, 79) != 0);
      drive($urandom_range(0, 3) != 0, 16'($urandom), 16'($urandom),
            $urandom_range(0, 2) != 0, $urandom_range(0, 19) == 0);
      step();
      check_model($sformatf("rand%0d", i));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
